// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, one-entry skid buffer,
// IF/ID pipeline register with branch flush and downstream stall.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [0:31] instr_d,
   output logic [31:0] pc_d,
   output logic        valid_d
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] skid_instr, skid_pc;
   logic            skid_load, ifid_load, ifid_from_skid, load_req;

   assign imem_addr = req_addr;

   // Next-state, next-pc and IF/ID load selection
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      skid_load      = 1'b0;
      ifid_load      = 1'b0;
      ifid_from_skid = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            if (imem_ack) begin
               pc_nxt = pc + XLEN'(4);
               if (!branch_taken) begin
                  if (stall) begin
                     skid_load = 1'b1;
                     state_nxt = HOLD;
                  end else begin
                     ifid_load = 1'b1;
                  end
               end
            end else if (branch_taken) begin
               state_nxt = DRAIN;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               state_nxt = FETCH;
            end else if (!stall) begin
               ifid_from_skid = 1'b1;
               state_nxt      = FETCH;
            end
         end
         DRAIN: if (imem_ack) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
      if (branch_taken) pc_nxt = branch_target & ~XLEN'(3);
   end

   // A new request address is latched only when no request is still outstanding
   assign load_req = (state_nxt == FETCH) && !((state == FETCH) && !imem_ack);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         req_addr   <= RESET_PC;
         imem_req   <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
         instr_d    <= NOP_INSTR;
         pc_d       <= '0;
         valid_d    <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         imem_req <= (state_nxt == FETCH) || (state_nxt == DRAIN);
         if (load_req) req_addr <= pc_nxt;
         if (skid_load) begin
            skid_instr <= imem_rdata;
            skid_pc    <= req_addr;
         end
         // Flush beats stall; stall freezes IF/ID; otherwise load or insert a bubble
         if (branch_taken) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
         end else if (ifid_load) begin
            valid_d <= 1'b1;
            instr_d <= imem_rdata;
            pc_d    <= req_addr;
         end else if (ifid_from_skid) begin
            valid_d <= 1'b1;
            instr_d <= skid_instr;
            pc_d    <= skid_pc;
         end else if (!stall) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
         end
      end
   end

endmodule
